// File: rtl/axi4lite_regfile.sv
// axi4lite_regfile -- AXI4-Lite slave exposing a bank of writable output
// registers and a bank of read-only input registers.
//
//   aclk, areset          clock, synchronous active-high reset
//   ctrl_ar* / ctrl_r*    read address / read data channels
//   ctrl_aw* / ctrl_w*    write address / write data channels
//   ctrl_b*               write response channel
//   reg_out [NOF_REGOUT]  register contents (byte 4*i)
//   reg_in  [NOF_REGIN]   sampled inputs (byte REGIN_OFFSET+4*j)
//   wr_pulse / rd_pulse   one-cycle strobes per register written / reg_in read
//
// Optional feature: define AXI4LITE_REGFILE_WSTRB_EN to honour ctrl_wstrb
// byte enables on commit; otherwise every commit writes the full word.

// One output register with byte-granular write enables.
module axi4lite_regfile_cell #(
  parameter logic [31:0] RST = '0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge aclk) begin
    if (areset) q <= RST;
    else if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) q[8*b +: 8] <= d[8*b +: 8];
  end
endmodule

module axi4lite_regfile #(
  parameter int                            NOF_REGOUT   = 4,
  parameter int                            NOF_REGIN    = 4,
  parameter logic [11:0]                   REGIN_OFFSET = 12'h800,
  parameter logic [NOF_REGOUT-1:0][31:0]   RESET_VALUE  = '0
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             ctrl_arvalid,
  output logic                             ctrl_arready,
  input  logic [11:0]                      ctrl_araddr,
  output logic                             ctrl_rvalid,
  input  logic                             ctrl_rready,
  output logic [31:0]                      ctrl_rdata,
  output logic [1:0]                       ctrl_rresp,
  input  logic                             ctrl_awvalid,
  output logic                             ctrl_awready,
  input  logic [11:0]                      ctrl_awaddr,
  input  logic                             ctrl_wvalid,
  output logic                             ctrl_wready,
  input  logic [31:0]                      ctrl_wdata,
  input  logic [3:0]                       ctrl_wstrb,
  output logic                             ctrl_bvalid,
  input  logic                             ctrl_bready,
  output logic [1:0]                       ctrl_bresp,
  output logic [NOF_REGOUT-1:0][31:0]      reg_out,
  input  logic [NOF_REGIN-1:0][31:0]       reg_in,
  output logic [NOF_REGOUT-1:0]            wr_pulse,
  output logic [NOF_REGIN-1:0]             rd_pulse
);
  localparam int REGIN_W = int'(REGIN_OFFSET[11:2]);

  // Byte lanes within a word carry no addressing meaning.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{ctrl_araddr[1:0], ctrl_awaddr[1:0]};

  // ---------------- read path ----------------
  logic [9:0]           ar_word;
  logic [31:0]          rd_data_nxt;
  logic [1:0]           rd_resp_nxt;
  logic [NOF_REGIN-1:0] rd_hit;

  assign ar_word      = ctrl_araddr[11:2];
  assign ctrl_arready = !ctrl_rvalid;

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = 2'b10;
    rd_hit      = '0;
    for (int i = 0; i < NOF_REGOUT; i++)
      if (int'(ar_word) == i) begin
        rd_data_nxt = reg_out[i];
        rd_resp_nxt = 2'b00;
      end
    for (int j = 0; j < NOF_REGIN; j++)
      if (int'(ar_word) == REGIN_W + j) begin
        rd_data_nxt = reg_in[j];
        rd_resp_nxt = 2'b00;
        rd_hit[j]   = 1'b1;
      end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ctrl_rvalid <= 1'b0;
      ctrl_rdata  <= '0;
      ctrl_rresp  <= 2'b00;
      rd_pulse    <= '0;
    end else begin
      rd_pulse <= '0;
      if (ctrl_arvalid && ctrl_arready) begin
        ctrl_rvalid <= 1'b1;
        ctrl_rdata  <= rd_data_nxt;
        ctrl_rresp  <= rd_resp_nxt;
        rd_pulse    <= rd_hit;
      end else if (ctrl_rvalid && ctrl_rready) begin
        ctrl_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- write path ----------------
  // AW and W each park in a one-entry holding register; the pair commits
  // once both are present and the previous response has been taken.
  logic                  aw_full, w_full, commit, wr_map;
  logic [9:0]            aw_word;
  logic [31:0]           w_data;
  logic [3:0]            w_strb, be;
  logic [NOF_REGOUT-1:0] wr_hit;

  assign ctrl_awready = !aw_full;
  assign ctrl_wready  = !w_full;
  assign commit       = aw_full && w_full && !ctrl_bvalid;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NOF_REGOUT; i++)
      if (int'(aw_word) == i) wr_hit[i] = 1'b1;
  end
  assign wr_map = |wr_hit;

`ifdef AXI4LITE_REGFILE_WSTRB_EN
  assign be = w_strb;
`else
  logic unused_strb;
  assign be          = 4'hF;
  assign unused_strb = ^w_strb;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      aw_word     <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      ctrl_bvalid <= 1'b0;
      ctrl_bresp  <= 2'b00;
      wr_pulse    <= '0;
    end else begin
      wr_pulse <= '0;
      if (ctrl_awvalid && ctrl_awready) begin
        aw_full <= 1'b1;
        aw_word <= ctrl_awaddr[11:2];
      end
      if (ctrl_wvalid && ctrl_wready) begin
        w_full <= 1'b1;
        w_data <= ctrl_wdata;
        w_strb <= ctrl_wstrb;
      end
      // commit needs both holders full, so it never collides with an accept
      if (commit) begin
        aw_full     <= 1'b0;
        w_full      <= 1'b0;
        ctrl_bvalid <= 1'b1;
        ctrl_bresp  <= wr_map ? 2'b00 : 2'b10;
        wr_pulse    <= wr_hit;
      end else if (ctrl_bvalid && ctrl_bready) begin
        ctrl_bvalid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NOF_REGOUT; i++) begin : g_reg
    axi4lite_regfile_cell #(.RST(RESET_VALUE[i])) u_cell (
      .aclk   (aclk),
      .areset (areset),
      .we     (commit && wr_hit[i]),
      .be     (be),
      .d      (w_data),
      .q      (reg_out[i])
    );
  end
endmodule
